// File: rtl/dmem_pkg.sv
// dmem_pkg: access-type and state encodings plus the lane byte-enable helper
package dmem_pkg;

    typedef enum logic [1:0] {
        DT_WORD = 2'b00,
        DT_HALF = 2'b01,
        DT_BYTE = 2'b10,
        DT_RSVD = 2'b11
    } dtype_t;

    // S_CHECK is the error-check step between accept and WAIT/ACCESS
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] t, input logic [1:0] a);
        return t == DT_BYTE ? 4'b0001 << a : t == DT_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a);
        return t == DT_BYTE ? 1'b0 : t == DT_HALF ? a[0] : |a;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response valid-ready bundle between the MEM stage and the responder
interface dmem_responder_if #(parameter int ADDR_W = 10);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_type;
    logic              req_unsigned;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_type, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_type, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store-lane merge and load-lane extraction with sign/zero extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  typ,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [3:0]  mask,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] rdata
);
    logic [31:0] bmask, steer, sh;

    assign bmask  = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    assign steer  = typ == DT_BYTE ? {4{wdata[7:0]}} : typ == DT_HALF ? {2{wdata[15:0]}} : wdata;
    assign merged = (steer & bmask) | (old_word & ~bmask);
    // shift amount ignores the sub-lane address bits, which also forces alignment
    assign sh     = old_word >> (typ == DT_BYTE ? {off, 3'b000} : typ == DT_HALF ? {off[1], 4'b0000} : 5'd0);
    assign rdata  = typ == DT_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
                    typ == DT_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with wait states and lane steering
// DMEM_ALIGN_CHECK_EN: report misaligned accesses as errors instead of forcing alignment
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, nxt;
    logic [3:0]        cnt;
    logic              r_write, r_uns, mis, err;
    logic [1:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, rdata, old_word, merged, ld;
    logic [31:0]       mem [DEPTH_WORDS];

    assign old_word = mem[r_addr[IDX_W+1:2]];

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = misaligned(r_type, r_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    dmem_lane_align u_align (
        .typ      (r_type),
        .off      (r_addr[1:0]),
        .uns      (r_uns),
        .mask     (lane_mask(r_type, r_addr[1:0])),
        .old_word (old_word),
        .wdata    (r_wdata),
        .merged   (merged),
        .rdata    (ld)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = bus.req_valid ? S_CHECK : S_IDLE;
            S_CHECK:  nxt = mis ? S_RESP : (WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS);
            S_WAIT:   nxt = cnt == 4'd0 ? S_ACCESS : S_WAIT;
            S_ACCESS: nxt = S_RESP;
            S_RESP:   nxt = bus.rsp_ready ? S_IDLE : S_RESP;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            r_write <= 1'b0;
            r_uns   <= 1'b0;
            r_type  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && bus.req_valid) begin
                r_write <= bus.req_write;
                r_uns   <= bus.req_unsigned;
                r_type  <= bus.req_type;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                rdata   <= '0;
                err     <= 1'b0;
            end
            if (state == S_CHECK) begin
                cnt <= 4'(WAIT_CYCLES - 1);
                err <= mis;
            end
            if (state == S_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == S_ACCESS)
                rdata <= r_write ? 32'h0 : ld;
        end
    end

    // storage array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && r_write)
            mem[r_addr[IDX_W+1:2]] <= merged;
    end

    assign bus.req_ready = state == S_IDLE;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Bus-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts programmable wait states, performs byte/halfword/word access with lane steering and sign/zero extension, and returns a response over a second valid/ready handshake.
- Sits between the core's MEM stage and the data storage array; replaces the zero-latency data memory when multi-cycle memory timing is exercised.

Parameters:
- ADDR_W, 10, byte-address width.
- DEPTH_WORDS, 256, number of 32-bit words stored. Address bits above the array size are ignored, so accesses wrap modulo DEPTH_WORDS*4.
- WAIT_CYCLES, 2, extra cycles between accept and access, 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bits are used for byte/half.
- req_type  in  2  access type: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- req_unsigned  in  1  zero-extend loads when 1.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not reset.
  - Reset mid-transaction abandons the request. A pending store that has not reached ACCESS is not written.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid, capture write, addr, wdata, type and unsigned into request registers. Go to ERR-check. If misaligned, go to RESP. Otherwise go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
  - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Exit to ACCESS when the counter is 0.
  - ACCESS: one cycle.
    - Store: read-modify-write of the addressed word; only the selected lanes change.
    - Load: word registered into rsp_rdata after lane extraction and extension.
    - Next state is RESP.
  - RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable. When rsp_ready=1, go to IDLE. req_ready stays 0 throughout RESP; there is no accept in the same cycle as the response handshake.
- Latency: a request accepted at edge N makes rsp_valid visible after edge N+WAIT_CYCLES+2. A misaligned request makes it visible after edge N+1.
- Lane mapping (little-endian):
  - Byte lane = addr[1:0].
  - Half lane = addr[1]. Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
- Load extension:
  - Byte loads replicate bit 7 of the extracted byte into bits 31:8 when req_unsigned=0; otherwise bits 31:8 are 0.
  - Half loads do the same from bit 15.
- Stores use req_wdata[7:0] for byte and req_wdata[15:0] for half, placed into the addressed lane.
- Misaligned accesses: the array is untouched, rsp_err=1 and rsp_rdata=0.
- Back-to-back operation: the earliest next accept is the cycle after the response handshake. Maximum throughput is one transaction per WAIT_CYCLES+3 cycles.
- A rsp_ready level held at 1 while rsp_valid=0 has no effect.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - Misalignment detection as above.
- Not defined:
  - rsp_err is tied to 0.
  - The low address bits are forced to alignment: word ignores addr[1:0]; half ignores addr[0].
  - The access proceeds normally through WAIT and ACCESS.

Decomposition:
- Shared package dmem_pkg:
  - Access-type encodings (DT_WORD=2'b00, DT_HALF=2'b01, DT_BYTE=2'b10).
  - FSM state encodings.
  - Function computing the lane byte-enable mask from type and addr[1:0].
- One combinational sub-module, dmem_lane_align:
  - Store path: merges write data into the old word given the mask.
  - Load path: extracts and extends a lane.
  - The responder instantiates it once.

Test Plan:
- Word store then load, WAIT_CYCLES=2: store addr 0x010, data 0xDEADBEEF; then load word 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid first seen 4 cycles after the accept edge.
- Byte lanes: after the word above, store byte 0x5A to 0x012; load word 0x010 -> 0xDE5ABEEF. Signed byte load 0x013 -> 0xFFFFFFDE. Unsigned byte load -> 0x000000DE.
- Half extension: store half 0x8001 to 0x020; signed half load -> 0xFFFF8001; unsigned -> 0x00008001.
- Misaligned (macro defined): word store to 0x011 -> rsp_err=1 one cycle after accept, and memory at 0x010 is unchanged. Macro undefined: the same store writes word 0x010.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0. Raise rsp_ready -> IDLE next cycle, and a new request is accepted.
- Reset mid-WAIT: store accepted, rst=0 during WAIT -> outputs return to reset values immediately, and a later load shows the old memory content.
